// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle UI events: press/release edges,
// single/double click, long press and auto-repeat while held.
module key_event_decoder #(
  parameter logic                 PRESS_LEVEL = 1'b0,
  parameter int unsigned          CNT_W       = 26,
  parameter logic [CNT_W-1:0]     LONG_TIME   = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0]     DOUBLE_GAP  = CNT_W'(12_500_000),
  parameter logic [CNT_W-1:0]     REPEAT_TIME = CNT_W'(10_000_000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_filter,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TIME   - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST    = DOUBLE_GAP  - CNT_W'(1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_TIME - CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_LONG   = 3'd2,
    S_GAP    = 3'd3,
    S_PRESS2 = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q;
  logic             press_q, release_q;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  logic             pressed_now;
  logic             press_edge;
  logic             release_edge;
  logic [CNT_W-1:0] cnt_inc;

  assign pressed_now  = (key_filter == PRESS_LEVEL);
  assign press_edge   = pressed_now & ~pressed_q;
  assign release_edge = ~pressed_now & pressed_q;
  assign cnt_inc      = cnt_q + CNT_W'(1);

  // Gesture FSM; edges take priority over timer thresholds in every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_edge) begin
          state_d = S_PRESS1;
          cnt_d   = '0;
        end
      end
      S_PRESS1: begin
        if (release_edge) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LONG: begin
        if (release_edge) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        if (press_edge) begin
          state_d = S_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PRESS2: begin
        // A held second press is never promoted to long press.
        if (release_edge) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Level tracks the key through reset so a held key yields no spurious press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pressed_q <= pressed_now;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_now;
      press_q   <= press_edge;
      release_q <= release_edge;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_state     = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign single_click  = single_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed segment table plus randomized key activity, checked against a
// timestamp-based gesture model.
module tb_key_event_decoder;

  localparam int LONG_T = 20;
  localparam int GAP_T  = 10;
  localparam int REP_T  = 5;

  logic clk;
  logic rst_n;
  logic key_filter;
  logic key_state, press_pulse, release_pulse;
  logic single_click, double_click, long_press, repeat_pulse;

  key_event_decoder #(
    .PRESS_LEVEL (1'b0),
    .CNT_W       (26),
    .LONG_TIME   (26'd20),
    .DOUBLE_GAP  (26'd10),
    .REPEAT_TIME (26'd5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_filter    (key_filter),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .single_click  (single_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Output vector: {key_state, press, release, single, double, long, repeat}
  function automatic logic [6:0] dut_vec();
    return {key_state, press_pulse, release_pulse, single_click,
            double_click, long_press, repeat_pulse};
  endfunction

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Reference model: gesture phases timed by absolute cycle stamps.
  typedef enum int {M_IDLE, M_HELD, M_LONGHELD, M_WAIT, M_SECOND} mode_e;
  mode_e      m_mode = M_IDLE;
  logic       m_prev = 1'b0;
  int         m_cyc  = 0;
  int         m_t0   = 0;
  logic [6:0] m_exp  = '0;

  task automatic model_edge(input logic r, input logic k);
    logic pn, pe, re;
    logic sc, dc, lp, rp;
    pn = (k == 1'b0);
    sc = 0; dc = 0; lp = 0; rp = 0;
    m_cyc++;
    if (!r) begin
      m_prev = pn;
      m_mode = M_IDLE;
      m_exp  = {pn, 6'b0};
      return;
    end
    pe = pn & ~m_prev;
    re = ~pn & m_prev;
    m_prev = pn;
    case (m_mode)
      M_IDLE:     if (pe) begin m_mode = M_HELD; m_t0 = m_cyc; end
      M_HELD:     if (re) begin m_mode = M_WAIT; m_t0 = m_cyc; end
                  else if (m_cyc - m_t0 == LONG_T) begin lp = 1; m_mode = M_LONGHELD; m_t0 = m_cyc; end
      M_LONGHELD: if (re) m_mode = M_IDLE;
                  else if ((m_cyc - m_t0) % REP_T == 0) rp = 1;
      M_WAIT:     if (pe) m_mode = M_SECOND;
                  else if (m_cyc - m_t0 == GAP_T) begin sc = 1; m_mode = M_IDLE; end
      M_SECOND:   if (re) begin dc = 1; m_mode = M_IDLE; end
      default:    m_mode = M_IDLE;
    endcase
    m_exp = {pn, pe, re, sc, dc, lp, rp};
  endtask

  task automatic step(input logic r, input logic k);
    rst_n      = r;
    key_filter = k;
    @(posedge clk);
    model_edge(r, k);
    #1;
    chk("model", dut_vec(), m_exp);
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic       key;
    int         len;
    int         off;    // cycle within segment checked against vec (0 = none)
    logic [6:0] vec;
  } seg_t;

  seg_t segs[$];

  initial begin
    rst_n      = 1'b0;
    key_filter = 1'b1;

    // 1: single click
    segs.push_back('{"reset",       0, 1,  2, 2, 7'b0000000});
    segs.push_back('{"t1_press",    1, 0,  5, 1, 7'b1100000});
    segs.push_back('{"t1_release",  1, 1, 10, 1, 7'b0010000});
    segs.push_back('{"t1_single",   1, 1,  5, 1, 7'b0001000});
    // 2: double click
    segs.push_back('{"t2_press1",   1, 0,  3, 1, 7'b1100000});
    segs.push_back('{"t2_rel1",     1, 1,  4, 1, 7'b0010000});
    segs.push_back('{"t2_press2",   1, 0,  3, 1, 7'b1100000});
    segs.push_back('{"t2_double",   1, 1, 12, 1, 7'b0010100});
    // 3: long press with repeats
    segs.push_back('{"t3_press",    1, 0, 20, 1, 7'b1100000});
    segs.push_back('{"t3_long",     1, 0,  5, 1, 7'b1000010});
    segs.push_back('{"t3_rep1",     1, 0,  5, 1, 7'b1000001});
    segs.push_back('{"t3_rep2",     1, 0,  2, 1, 7'b1000001});
    segs.push_back('{"t3_release",  1, 1, 15, 1, 7'b0010000});
    // 4: second press on the gap-threshold cycle
    segs.push_back('{"t4_press1",   1, 0,  3, 1, 7'b1100000});
    segs.push_back('{"t4_rel1",     1, 1, 10, 1, 7'b0010000});
    segs.push_back('{"t4_press2",   1, 0,  3, 1, 7'b1100000});
    segs.push_back('{"t4_double",   1, 1, 12, 1, 7'b0010100});
    // 5: reset while pressed
    segs.push_back('{"t5_press",    1, 0,  4, 1, 7'b1100000});
    segs.push_back('{"t5_reset",    0, 0,  2, 2, 7'b1000000});
    segs.push_back('{"t5_held",     1, 0, 25, 1, 7'b1000000});
    segs.push_back('{"t5_release",  1, 1, 12, 1, 7'b0010000});
    // 6: release on the long-threshold cycle
    segs.push_back('{"t6_press",    1, 0, 20, 1, 7'b1100000});
    segs.push_back('{"t6_release",  1, 1, 10, 1, 7'b0010000});
    segs.push_back('{"t6_single",   1, 1,  5, 1, 7'b0001000});

    foreach (segs[s]) begin
      for (int i = 1; i <= segs[s].len; i++) begin
        step(segs[s].rst, segs[s].key);
        if (i == segs[s].off) chk(segs[s].name, dut_vec(), segs[s].vec);
      end
    end

    // Randomized key activity with occasional resets
    for (int s = 0; s < 160; s++) begin
      logic r, k;
      int   len;
      r   = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      k   = 1'($urandom_range(0, 1));
      len = r ? int'($urandom_range(1, 26)) : int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) step(r, k);
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
